// File: rtl/tt_bin_clock_pkg.sv
// Shared field limits, widths and the HH:MM:SS(+pm) record for the binary timekeeper.
package tt_bin_clock_pkg;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [SEC_W-1:0]  SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX = 6'd59;
    localparam logic [HOUR_W-1:0] H12_MIN = 5'd1;
    localparam logic [HOUR_W-1:0] H12_MAX = 5'd12;
    localparam logic [HOUR_W-1:0] H24_MAX = 5'd23;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic              pm;
    } hms_t;

    // Minutes and seconds share width and range, so one wrap helper serves both.
    function automatic logic [5:0] wrap6(input logic [5:0] v, input logic [5:0] hi,
                                         input logic inc);
        if (inc) return (v == hi) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? hi : v - 6'd1;
    endfunction
endpackage

// File: rtl/tt_bin_clock_btn.sv
// Button conditioner: registered edge detect plus hold-to-repeat stepping.
module tt_bin_clock_btn
    import tt_bin_clock_pkg::*;
#(
    parameter int REPEAT_CYC = 50
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    input  logic en_i,
    output logic edge_o,
    output logic step_o
);
    localparam int CNT_W = $clog2(REPEAT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REPEAT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rpt;

    assign edge_o = btn_i & ~prev_q;
    assign rpt    = en_i & btn_i & (cnt_q == CNT_MAX);
    assign step_o = en_i & (edge_o | rpt);

    // The hold counter only runs once started by an edge while enabled, so a hold
    // that survives a run/set toggle never repeats until released and pressed again.
    always_comb begin
        cnt_d = '0;
        if (en_i && btn_i) begin
            if (edge_o || rpt)
                cnt_d = CNT_ONE;
            else if (cnt_q != '0)
                cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= btn_i;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/tt_bin_timekeeper.sv
// Binary HH:MM:SS wall clock with 1 Hz prescaler and button time setting.
// Optional alarm compare enabled by defining TT_BIN_TIMEKEEPER_ALARM_EN.
module tt_bin_timekeeper
    import tt_bin_clock_pkg::*;
#(
    parameter int CLK_HZ     = 100,
    parameter bit MODE_24H   = 1'b0,
    parameter int REPEAT_CYC = 50
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              time_set_i,
    input  logic              id_switch_i,
    input  logic              hour_id_i,
    input  logic              minute_id_i,
    input  logic              seconds_id_i,
    input  logic              alarm_sel_i,
    output logic [HOUR_W-1:0] hour_out,
    output logic [MIN_W-1:0]  minute_out,
    output logic [SEC_W-1:0]  seconds_out,
    output logic              pm_o,
    output logic              tick_o,
    output logic              alarm_o
);
    localparam int PRE_W = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam hms_t HMS_RST = '{hour: (MODE_24H ? 5'd0 : H12_MAX), min: 6'd0,
                                 sec: 6'd0, pm: 1'b0};

    hms_t             time_q, time_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick;
    logic             step_h, step_m, step_s, edge_h, edge_m, edge_s;

    // Hour stepping is shared by set mode and the run-mode carry; in 12 h mode
    // crossing 11<->12 is where AM/PM flips.
    function automatic hms_t bump_hour(input hms_t t, input logic inc);
        hms_t r;
        logic [HOUR_W-1:0] lo, hi;
        r  = t;
        lo = MODE_24H ? 5'd0 : H12_MIN;
        hi = MODE_24H ? H24_MAX : H12_MAX;
        if (inc) r.hour = (t.hour == hi) ? lo : t.hour + 5'd1;
        else     r.hour = (t.hour == lo) ? hi : t.hour - 5'd1;
        if (!MODE_24H && ((inc && t.hour == H12_MAX - 5'd1) || (!inc && t.hour == H12_MAX)))
            r.pm = ~t.pm;
        return r;
    endfunction

    function automatic hms_t bump_min(input hms_t t, input logic inc);
        hms_t r;
        r     = t;
        r.min = wrap6(t.min, MIN_MAX, inc);
        return r;
    endfunction

    function automatic hms_t bump_sec(input hms_t t, input logic inc);
        hms_t r;
        r     = t;
        r.sec = wrap6(t.sec, SEC_MAX, inc);
        return r;
    endfunction

    function automatic hms_t advance(input hms_t t);
        hms_t r;
        r = t;
        if (t.sec != SEC_MAX) begin
            r.sec = t.sec + 6'd1;
        end else begin
            r.sec = '0;
            if (t.min != MIN_MAX) begin
                r.min = t.min + 6'd1;
            end else begin
                r.min = '0;
                r     = bump_hour(r, 1'b1);
            end
        end
        return r;
    endfunction

    tt_bin_clock_btn #(.REPEAT_CYC(REPEAT_CYC)) u_btn_h (
        .clk_i(clk_i), .reset_i(reset_i), .btn_i(hour_id_i), .en_i(time_set_i),
        .edge_o(edge_h), .step_o(step_h));
    tt_bin_clock_btn #(.REPEAT_CYC(REPEAT_CYC)) u_btn_m (
        .clk_i(clk_i), .reset_i(reset_i), .btn_i(minute_id_i), .en_i(time_set_i),
        .edge_o(edge_m), .step_o(step_m));
    tt_bin_clock_btn #(.REPEAT_CYC(REPEAT_CYC)) u_btn_s (
        .clk_i(clk_i), .reset_i(reset_i), .btn_i(seconds_id_i), .en_i(time_set_i),
        .edge_o(edge_s), .step_o(step_s));

    assign tick = ~time_set_i & (presc_q == PRE_LAST);

`ifdef TT_BIN_TIMEKEEPER_ALARM_EN
    hms_t alarm_q, alarm_d;
    logic act_q, act_d;

    always_comb begin
        time_d  = time_q;
        presc_d = presc_q;
        alarm_d = alarm_q;
        if (time_set_i) begin
            presc_d = '0;
            // Alarm edit ignores the seconds button: the alarm is HH:MM only.
            if (alarm_sel_i) begin
                if (step_m)      alarm_d = bump_min(alarm_q, id_switch_i);
                else if (step_h) alarm_d = bump_hour(alarm_q, id_switch_i);
            end else begin
                if (step_s)      time_d = bump_sec(time_q, id_switch_i);
                else if (step_m) time_d = bump_min(time_q, id_switch_i);
                else if (step_h) time_d = bump_hour(time_q, id_switch_i);
            end
        end else if (tick) begin
            presc_d = '0;
            time_d  = advance(time_q);
        end else begin
            presc_d = presc_q + PRE_ONE;
        end

        act_d = act_q;
        if (edge_h || edge_m || edge_s)
            act_d = 1'b0;
        else if (tick && time_d == alarm_q)
            act_d = 1'b1;
        else if (time_d.min != time_q.min)
            act_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            alarm_q <= HMS_RST;
            act_q   <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
            act_q   <= act_d;
        end
    end

    assign alarm_o = act_q;
`else
    logic unused_inputs;

    always_comb begin
        time_d  = time_q;
        presc_d = presc_q;
        if (time_set_i) begin
            presc_d = '0;
            if (step_s)      time_d = bump_sec(time_q, id_switch_i);
            else if (step_m) time_d = bump_min(time_q, id_switch_i);
            else if (step_h) time_d = bump_hour(time_q, id_switch_i);
        end else if (tick) begin
            presc_d = '0;
            time_d  = advance(time_q);
        end else begin
            presc_d = presc_q + PRE_ONE;
        end
    end

    assign unused_inputs = alarm_sel_i ^ edge_h ^ edge_m ^ edge_s;
    assign alarm_o       = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            time_q  <= HMS_RST;
            presc_q <= '0;
        end else begin
            time_q  <= time_d;
            presc_q <= presc_d;
        end
    end

    assign hour_out    = time_q.hour;
    assign minute_out  = time_q.min;
    assign seconds_out = time_q.sec;
    assign pm_o        = time_q.pm;
    assign tick_o      = tick;
endmodule
